seq_gen: RTL and testbench

- Serial pattern transmitter that drives the single-bit input of the sequence detector (`SD`, serial input `X`).
- Loads a parallel pattern and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable idle gap between repetitions.
- Used as the stimulus/source end of the serial-sequence link, in benches and in on-chip self-test.

---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_gen_shift_reg.sv | 60 ++++++
 rtl/seq_gen.sv | 160 ++++++++++++++++
 tb/tb_seq_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter (seq_gen) and its
// shift-register helper: FSM state encoding, the default pattern and the
// default counter widths.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int          DEF_PATTERN_LEN = 4;
    localparam logic [3:0]  DEF_PATTERN_C   = 4'b1101;
    localparam int          DEF_CNT_W       = 4;
    localparam int          DEF_GAP_W       = 4;

endpackage

// File: rtl/seq_gen_shift_reg.sv
// Loadable shift register for seq_gen. Holds a latched copy of the pattern
// so every repetition can be reloaded without re-reading the input port.
// The MSB of the shift register is the serial output directly; shifting
// fills with IDLE_LEVEL, so once a frame has been fully shifted out the
// output already sits at the idle level. With PAR_EN the frame carries the
// even-parity bit of the pattern behind the LSB.
module seq_shift_reg #(
    parameter int                     PATTERN_LEN = 4,
    parameter bit                     PAR_EN      = 1'b0,
    parameter logic                   IDLE_LEVEL  = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      latch_i,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [PATTERN_LEN-1:0]    pat_i,
    output logic                      msb_o
);

    localparam int W = PATTERN_LEN + int'(PAR_EN);

    logic [PATTERN_LEN-1:0] pat_q;
    logic [PATTERN_LEN-1:0] src;
    logic [W-1:0]           frame_w;
    logic [W-1:0]           sr_q;
    logic [W-1:0]           sr_d;

    // A load in the same cycle as a latch takes the fresh pattern directly.
    assign src = latch_i ? pat_i : pat_q;

    generate
        if (PAR_EN) begin : g_par
            assign frame_w = {src, ^src};
        end else begin : g_nopar
            assign frame_w = src;
        end
    endgenerate

    // Pattern copy: data only, never reset.
    always_ff @(posedge clk_i) begin
        if (latch_i) pat_q <= pat_i;
    end

    // Next shift-register contents: load a frame, shift MSB-first, or hold.
    always_comb begin
        sr_d = sr_q;
        if (load_i)       sr_d = frame_w;
        else if (shift_i) sr_d = {sr_q[W-2:0], IDLE_LEVEL};
    end

    // Shift register; reset to idle since its MSB is the serial line.
    always_ff @(posedge clk_i) begin
        if (rst_i) sr_q <= {W{IDLE_LEVEL}};
        else       sr_q <= sr_d;
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. Loads a parallel pattern on Start,
// shifts it out MSB-first Repeat times with Gap idle cycles in between,
// then pulses Done. All outputs come straight from registers.
// Optional build macro: SEQ_GEN_PARITY_EN appends an even-parity bit to
// every repetition.
module seq_gen
    import seq_pkg::*;
#(
    parameter int                      PATTERN_LEN = DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0]  DEF_PATTERN = DEF_PATTERN_C,
    parameter int                      CNT_W       = DEF_CNT_W,
    parameter int                      GAP_W       = DEF_GAP_W,
    parameter logic                    IDLE_LEVEL  = 1'b0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Start,
    input  logic                       UseDefault,
    input  logic [PATTERN_LEN-1:0]     Pattern,
    input  logic [CNT_W-1:0]           Repeat,
    input  logic [GAP_W-1:0]           Gap,
    output logic                       X,
    output logic                       Valid,
    output logic                       Busy,
    output logic                       Done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int               IDX_W   = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PATTERN_LEN - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic               par_q, par_d;
    logic               valid_q, busy_q, done_q;
    logic               latch, load, shift, last;
    logic [PATTERN_LEN-1:0] pat_sel;

    assign pat_sel = UseDefault ? DEF_PATTERN : Pattern;

    // The last bit of a repetition is bit 0, or the parity bit when enabled.
    assign last = PAR_EN ? par_q : (idx_q == '0);

    // Next-state, counter and shift-register control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        par_d   = par_q;
        latch   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    latch = 1'b1;
                    rep_d = Repeat;
                    gap_d = Gap;
                    idx_d = IDX_MSB;
                    par_d = 1'b0;
                    if (Repeat == '0) begin
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (!last) begin
                    shift = 1'b1;
                    if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
                    else             par_d = 1'b1;
                end else begin
                    rep_d = rep_q - CNT_W'(1);
                    idx_d = IDX_MSB;
                    par_d = 1'b0;
                    if (rep_q == CNT_W'(1)) begin
                        shift   = 1'b1;
                        state_d = DONE;
                    end else if (gap_q != '0) begin
                        shift   = 1'b1;
                        gcnt_d  = gap_q;
                        state_d = GAP;
                    end else begin
                        // Back-to-back repetition: reload, no idle cycle.
                        load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == GAP_W'(1)) begin
                    gcnt_d  = '0;
                    load    = 1'b1;
                    state_d = SEND;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            par_q   <= par_d;
            valid_q <= (state_d == SEND);
            busy_q  <= (state_d == SEND) || (state_d == GAP);
            done_q  <= (state_d == DONE);
        end
    end

    seq_shift_reg #(
        .PATTERN_LEN (PATTERN_LEN),
        .PAR_EN      (PAR_EN),
        .IDLE_LEVEL  (IDLE_LEVEL)
    ) u_sr (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .latch_i (latch),
        .load_i  (load),
        .shift_i (shift),
        .pat_i   (pat_sel),
        .msb_o   (X)
    );

    assign Valid = valid_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: a per-cycle vector table of inputs and the
// expected {X, Valid, Busy, Done} after each edge, plus hand-written runs
// for the longest transfer and a 1101 detector on the serial stream.
// Build with SEQ_GEN_PARITY_EN defined to exercise the parity variant.
module tb_seq_gen;

`ifdef SEQ_GEN_PARITY_EN
    localparam int FR = 5;
`else
    localparam int FR = 4;
`endif

    logic       Clk = 1'b0;
    logic       Rst, Start, UseDefault;
    logic [3:0] Pattern, Repeat, Gap;
    logic       X, Valid, Busy, Done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst, start, usedef;
        logic [3:0] pat, rep, gap;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vq[$];

    seq_gen dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .UseDefault (UseDefault),
        .Pattern    (Pattern),
        .Repeat     (Repeat),
        .Gap        (Gap),
        .X          (X),
        .Valid      (Valid),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    function automatic void add(input logic r, input logic s, input logic u,
                                input logic [3:0] p, input logic [3:0] n,
                                input logic [3:0] g, input logic [3:0] e,
                                input string nm);
        vec_t v;
        v.rst = r; v.start = s; v.usedef = u;
        v.pat = p; v.rep = n; v.gap = g; v.exp = e; v.name = nm;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input int got, input int req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic u,
                         input logic [3:0] p, input logic [3:0] n, input logic [3:0] g);
        Rst = r; Start = s; UseDefault = u; Pattern = p; Repeat = n; Gap = g;
    endtask

    initial begin
        int   vcnt, done_at, det, cyc;
        logic [3:0] hist;
        logic [3:0] got;

        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        // fields: rst start usedef pat rep gap  expected {X,Valid,Busy,Done}
        add(1, 1, 0, 4'h0, 4'h1, 4'h0, 4'b0000, "reset");
        add(1, 1, 0, 4'h0, 4'h1, 4'h0, 4'b0000, "reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "idle");
`ifdef SEQ_GEN_PARITY_EN
        add(0, 1, 1, 4'h0, 4'h1, 4'h0, 4'b1110, "par_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "par_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0001, "par_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "par_def");
        add(0, 1, 0, 4'hB, 4'h2, 4'h1, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0010, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0001, "par_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "par_gap");
`else
        add(0, 1, 1, 4'h0, 4'h1, 4'h0, 4'b1110, "single_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "single_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "single_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "single_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0001, "single_def");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "single_def");
        add(0, 1, 0, 4'hB, 4'h2, 4'h3, 4'b1110, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "rep_gap");
        add(0, 1, 0, 4'h0, 4'h5, 4'h1, 4'b1110, "rep_gap_busy_start");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0010, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0010, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0010, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "rep_gap");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0001, "rep_gap");
        add(0, 1, 1, 4'h0, 4'h1, 4'h0, 4'b0000, "start_in_done");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "start_in_done");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "start_in_done");
        add(0, 1, 0, 4'hF, 4'h0, 4'h0, 4'b0001, "zero_rep");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "zero_rep");
        add(0, 1, 0, 4'h6, 4'h2, 4'h0, 4'b0110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0001, "gap0");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "gap0");
        add(0, 1, 0, 4'hF, 4'h3, 4'h0, 4'b1110, "mid_reset");
        add(0, 0, 0, 4'hF, 4'h3, 4'h0, 4'b1110, "mid_reset");
        add(1, 0, 0, 4'hF, 4'h3, 4'h0, 4'b0000, "mid_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "mid_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "mid_reset");
        add(0, 1, 1, 4'h0, 4'h1, 4'h0, 4'b1110, "after_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "after_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0110, "after_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b1110, "after_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0001, "after_reset");
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'b0000, "after_reset");
`endif

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].start, vq[i].usedef, vq[i].pat, vq[i].rep, vq[i].gap);
            @(posedge Clk); #1;
            got = {X, Valid, Busy, Done};
            tests++;
            if (got !== vq[i].exp) begin
                fails++;
                $display("FAIL %s[%0d]: XVBD got %b, required %b", vq[i].name, i, got, vq[i].exp);
            end
        end

        // Longest transfer: Repeat and Gap at their maximum values.
        drive(1'b0, 1'b1, 1'b0, 4'hA, 4'hF, 4'hF);
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        vcnt = 0; done_at = 0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (Valid) vcnt++;
            if (Done) begin
                done_at = cyc;
                break;
            end
            @(posedge Clk); #1;
        end
        check("max_run_done_cycle", done_at, 15 * FR + 14 * 15 + 1);
        check("max_run_valid_cycles", vcnt, 15 * FR);
        @(posedge Clk); #1;

        // Detector on the serial stream: 1101 twice, no gap.
        drive(1'b0, 1'b1, 1'b0, 4'hD, 4'h2, 4'h0);
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        hist = 4'h0; det = 0; vcnt = 0;
        for (int k = 0; k < 14; k++) begin
            if (Valid) begin
                vcnt++;
                hist = {hist[2:0], X};
                if (hist == 4'b1101) det++;
            end
            @(posedge Clk); #1;
        end
        check("detector_hits", det, 2);
        check("detector_valid_cycles", vcnt, 2 * FR);
        check("detector_end_idle", int'({X, Valid, Busy, Done}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
